// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT input/output staging blocks:
// block geometry, default pipeline depth and the JPEG zigzag scan table.
package idct_pkg;

    localparam int BLK_DIM              = 8;
    localparam int BLK_N                = BLK_DIM * BLK_DIM;
    localparam int WIN_DEFAULT          = 12;
    localparam int IDCT_LATENCY_DEFAULT = 26;

    typedef logic signed [WIN_DEFAULT-1:0] coeff_t;
    typedef logic                          bank_t;

    // Scan position -> raster index (r*8+c) for the JPEG zigzag order.
    localparam int ZZ2RASTER [0:BLK_N-1] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

endpackage

// File: rtl/idct_valid_pipe.sv
// Valid-tag delay line: a bit entering on i_bit appears on o_bit DEPTH cycles later.
module idct_valid_pipe #(
    parameter int DEPTH = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_bit,
    output logic o_bit
);

    logic [DEPTH-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr <= (r_sr << 1) | DEPTH'(i_bit);
        end
    end

    assign o_bit = r_sr[DEPTH-1];

endmodule

// File: rtl/idct_block_loader.sv
// Serial coefficient stream -> 8x8 raster blocks in a ping-pong buffer,
// presented whole on the IDCT input bus, with a tag aligned to the IDCT output.
module idct_block_loader
    import idct_pkg::*;
#(
    parameter int WIN          = WIN_DEFAULT,
    parameter int IDCT_LATENCY = IDCT_LATENCY_DEFAULT,
    parameter bit ZIGZAG       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIN-1:0]       in_data,
    input  logic                 in_last,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [BLK_N*WIN-1:0] blk_data,
    output logic                 idct_out_valid,
    output logic                 sync_err
);

    logic [BLK_N*WIN-1:0] r_bank [2];
    logic [1:0]           r_full;
    bank_t                r_fill;
    bank_t                r_drain;
    logic [5:0]           r_cnt;
    logic                 r_sync_err;

    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_cnt_end;
    logic [5:0]           w_addr;

    // in_ready depends on registered state only, never on blk_ready.
    assign in_ready  = ~r_full[r_fill];
    assign blk_valid = |r_full;
    assign w_accept  = in_valid & in_ready;
    assign w_xfer    = blk_valid & blk_ready;
    assign w_cnt_end = (r_cnt == 6'd63);
    assign w_addr    = ZIGZAG ? 6'(ZZ2RASTER[r_cnt]) : r_cnt;
    assign blk_data  = blk_valid ? r_bank[r_drain] : '0;
    assign sync_err  = r_sync_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank[0] <= '0;
            r_bank[1] <= '0;
        end else if (w_accept) begin
            r_bank[r_fill][int'(w_addr)*WIN +: WIN] <= in_data;
        end
    end

    // Completion sets the fill bank, transfer clears the drain bank; when both
    // fire on one edge they necessarily address different banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full     <= '0;
            r_fill     <= 1'b0;
            r_drain    <= 1'b0;
            r_cnt      <= '0;
            r_sync_err <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_cnt_end) begin
                    r_full[r_fill] <= 1'b1;
                    r_fill         <= ~r_fill;
                    r_cnt          <= '0;
                    if (!in_last) begin
                        r_sync_err <= 1'b1;
                    end
                end else if (in_last) begin
                    r_sync_err <= 1'b1;
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= r_cnt + 6'd1;
                end
            end
            if (w_xfer) begin
                r_full[r_drain] <= 1'b0;
                r_drain         <= ~r_drain;
            end
        end
    end

    idct_valid_pipe #(
        .DEPTH (IDCT_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_bit (w_xfer),
        .o_bit (idct_out_valid)
    );

endmodule

// File: tb/tb_idct_block_loader.sv
// Bench for idct_block_loader: a raster and a zigzag instance share one stream;
// a block/tag scoreboard checks every cycle, scenario tasks add targeted checks.
module tb_idct_block_loader;

    localparam int W   = 12;
    localparam int N   = 64;
    localparam int LAT = 26;

    typedef logic [N*W-1:0] blk_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         blk_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic in_ready_r, blk_valid_r, ov_r, sync_r;
    logic in_ready_z, blk_valid_z, ov_z, sync_z;
    blk_t data_r, data_z;

    idct_block_loader #(.WIN(W), .IDCT_LATENCY(LAT), .ZIGZAG(1'b0)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_data(in_data), .in_last(in_last), .blk_valid(blk_valid_r),
        .blk_ready(blk_ready), .blk_data(data_r), .idct_out_valid(ov_r),
        .sync_err(sync_r));

    idct_block_loader #(.WIN(W), .IDCT_LATENCY(LAT), .ZIGZAG(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
        .in_data(in_data), .in_last(in_last), .blk_valid(blk_valid_z),
        .blk_ready(blk_ready), .blk_data(data_z), .idct_out_valid(ov_z),
        .sync_err(sync_z));

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nxfer = 0;
    int   zz [N];
    int   mcnt = 0;
    bit   exp_sync = 1'b0;
    blk_t cur_r = '0;
    blk_t cur_z = '0;
    blk_t qr [$];
    blk_t qz [$];
    int   tagq [$];

    always @(posedge clk) cyc++;

    // Scoreboard: handshake flags, sticky error, block contents and tag timing.
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_t;
            total++;
            if (blk_valid_r !== (qr.size() > 0) || blk_valid_z !== (qr.size() > 0)) begin
                bad++;
                $display("FAIL blk_valid cyc=%0d got=%b/%b exp=%b", cyc, blk_valid_r, blk_valid_z, qr.size() > 0);
            end
            total++;
            if (in_ready_r !== (qr.size() < 2) || in_ready_z !== (qr.size() < 2)) begin
                bad++;
                $display("FAIL in_ready cyc=%0d got=%b/%b exp=%b", cyc, in_ready_r, in_ready_z, qr.size() < 2);
            end
            total++;
            if (sync_r !== exp_sync || sync_z !== exp_sync) begin
                bad++;
                $display("FAIL sync_err cyc=%0d got=%b/%b exp=%b", cyc, sync_r, sync_z, exp_sync);
            end
            exp_t = (tagq.size() > 0) && (tagq[0] == cyc);
            if (exp_t) void'(tagq.pop_front());
            total++;
            if (ov_r !== exp_t || ov_z !== exp_t) begin
                bad++;
                $display("FAIL idct_out_valid cyc=%0d got=%b/%b exp=%b", cyc, ov_r, ov_z, exp_t);
            end
            if (blk_valid_r && blk_ready) begin
                nxfer++;
                tagq.push_back(cyc + LAT);
                total++;
                if (qr.size() == 0) begin
                    bad++;
                    $display("FAIL xfer_unexpected cyc=%0d got=1 exp=0", cyc);
                end else begin
                    blk_t er, ez;
                    er = qr.pop_front();
                    ez = qz.pop_front();
                    if (data_r !== er) begin
                        bad++;
                        $display("FAIL blk_data_raster got=%h exp=%h", data_r, er);
                    end
                    total++;
                    if (data_z !== ez) begin
                        bad++;
                        $display("FAIL blk_data_zigzag got=%h exp=%h", data_z, ez);
                    end
                end
            end
        end
    end

    task automatic model_accept(input logic [W-1:0] v, input bit last);
        cur_r[mcnt*W +: W] = v;
        cur_z[zz[mcnt]*W +: W] = v;
        if (mcnt == N-1) begin
            qr.push_back(cur_r);
            qz.push_back(cur_z);
            mcnt = 0;
            if (!last) exp_sync = 1'b1;
        end else if (last) begin
            exp_sync = 1'b1;
            mcnt = 0;
        end else begin
            mcnt++;
        end
    endtask

    task automatic send(input logic [W-1:0] v, input bit last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = v;
        in_last  = last;
        while (!in_ready_r && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready_r) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=in_ready 0 exp=in_ready 1");
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(posedge clk); #1;
        model_accept(v, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_block(input int base, input bit with_last);
        for (int k = 0; k < N; k++) send(W'(base + k), with_last && (k == N-1));
    endtask

    task automatic drain_tags();
        int t = 0;
        while ((tagq.size() > 0 || qr.size() > 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (tagq.size() > 0 || qr.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d/%0d pending exp=0", tagq.size(), qr.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready_r !== 1'b1 || blk_valid_r !== 1'b0 || data_r !== '0 ||
            ov_r !== 1'b0 || sync_r !== 1'b0 || blk_valid_z !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got=rdy%b vld%b ov%b err%b exp=rdy1 vld0 ov0 err0",
                     in_ready_r, blk_valid_r, ov_r, sync_r);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_raster_ramp();
        int c0;
        blk_ready = 1'b1;
        for (int k = 0; k < N; k++) send(W'(-k), k == N-1);
        @(negedge clk);
        c0 = cyc;
        total++;
        if (blk_valid_r !== 1'b1) begin
            bad++;
            $display("FAIL ramp_valid got=%b exp=1", blk_valid_r);
        end
        for (int k = 0; k < N; k++) begin
            logic [W-1:0] e;
            e = data_r[k*W +: W];
            total++;
            if (e !== W'(-k)) begin
                bad++;
                $display("FAIL ramp_elem k=%0d got=%h exp=%h", k, e, W'(-k));
            end
        end
        @(negedge clk);
        total++;
        if (blk_valid_r !== 1'b0) begin
            bad++;
            $display("FAIL ramp_valid_drop got=%b exp=0", blk_valid_r);
        end
        while (cyc < c0 + LAT) @(negedge clk);
        total++;
        if (ov_r !== 1'b1) begin
            bad++;
            $display("FAIL ramp_tag got=%b exp=1", ov_r);
        end
        @(negedge clk);
        total++;
        if (ov_r !== 1'b0) begin
            bad++;
            $display("FAIL ramp_tag_len got=%b exp=0", ov_r);
        end
        drain_tags();
    endtask

    task automatic test_zigzag();
        int pos [7] = '{0, 1, 8, 16, 9, 2, 63};
        int val [7] = '{0, 1, 2, 3, 4, 5, 63};
        blk_ready = 1'b0;
        send_block(0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            logic [W-1:0] e;
            e = data_z[pos[i]*W +: W];
            total++;
            if (e !== W'(val[i])) begin
                bad++;
                $display("FAIL zigzag_raster[%0d] got=%0d exp=%0d", pos[i], e, val[i]);
            end
        end
        @(posedge clk); #1 blk_ready = 1'b1;
        @(posedge clk); #1 blk_ready = 1'b0;
        drain_tags();
    endtask

    task automatic test_backpressure();
        blk_t b0, b1;
        for (int k = 0; k < N; k++) begin
            b0[k*W +: W] = W'(100 + k);
            b1[k*W +: W] = W'(1000 + k);
        end
        blk_ready = 1'b0;
        send_block(100, 1'b1);
        send_block(1000, 1'b1);
        total++;
        if (in_ready_r !== 1'b0 || data_r !== b0) begin
            bad++;
            $display("FAIL bp_hold got=rdy%b data0_ok=%b exp=rdy0 data0_ok=1", in_ready_r, data_r === b0);
        end
        blk_ready = 1'b1;
        @(posedge clk); #1 blk_ready = 1'b0;
        total++;
        if (blk_valid_r !== 1'b1 || in_ready_r !== 1'b1 || data_r !== b1) begin
            bad++;
            $display("FAIL bp_next got=vld%b rdy%b data1_ok=%b exp=vld1 rdy1 data1_ok=1",
                     blk_valid_r, in_ready_r, data_r === b1);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        send_block(2000, 1'b1);
        blk_ready = 1'b1;
        @(negedge clk);
        c0 = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1 blk_ready = 1'b0;
        total++;
        if (blk_valid_r !== 1'b0) begin
            bad++;
            $display("FAIL b2b_empty got=%b exp=0", blk_valid_r);
        end
        while (cyc < c0 + LAT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ov_r !== (i < 2)) begin
                bad++;
                $display("FAIL b2b_tag[%0d] got=%b exp=%b", i, ov_r, i < 2);
            end
            @(negedge clk);
        end
        drain_tags();
    endtask

    task automatic test_sync_err();
        blk_ready = 1'b1;
        for (int k = 0; k < 40; k++) send(W'(500 + k), k == 39);
        @(negedge clk);
        total++;
        if (sync_r !== 1'b1 || blk_valid_r !== 1'b0) begin
            bad++;
            $display("FAIL sync_early got=err%b vld%b exp=err1 vld0", sync_r, blk_valid_r);
        end
        send_block(3000, 1'b1);
        drain_tags();
        total++;
        if (sync_r !== 1'b1) begin
            bad++;
            $display("FAIL sync_sticky got=%b exp=1", sync_r);
        end
    endtask

    task automatic test_reset_mid();
        int n0, hits;
        blk_ready = 1'b0;
        send_block(10, 1'b1);
        send_block(700, 1'b1);
        blk_ready = 1'b1;
        @(posedge clk); #1 blk_ready = 1'b0;
        for (int k = 0; k < 15; k++) send(W'(3500 + k), 1'b0);
        #3 rst_n = 1'b0;
        qr.delete();
        qz.delete();
        tagq.delete();
        mcnt = 0;
        exp_sync = 1'b0;
        #1;
        total++;
        if (in_ready_r !== 1'b1 || blk_valid_r !== 1'b0 || data_r !== '0 ||
            ov_r !== 1'b0 || sync_r !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs got=rdy%b vld%b ov%b err%b exp=rdy1 vld0 ov0 err0",
                     in_ready_r, blk_valid_r, ov_r, sync_r);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov_r || ov_z) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL midreset_tag got=%0d exp=0", hits);
        end
        n0 = nxfer;
        blk_ready = 1'b1;
        send_block(1500, 1'b1);
        repeat (5) @(negedge clk);
        total++;
        if (nxfer - n0 != 1) begin
            bad++;
            $display("FAIL midreset_blocks got=%0d exp=1", nxfer - n0);
        end
        drain_tags();
    endtask

    task automatic test_missing_last();
        int n0;
        n0 = nxfer;
        blk_ready = 1'b1;
        send_block(40, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if (sync_r !== 1'b1 || nxfer - n0 != 1) begin
            bad++;
            $display("FAIL missing_last got=err%b blocks%0d exp=err1 blocks1", sync_r, nxfer - n0);
        end
        drain_tags();
    endtask

    initial begin
        int p = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz[p] = r * 8 + (s - r);
                    p++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz[p] = r * 8 + (s - r);
                    p++;
                end
            end
        end
        test_reset();
        test_raster_ramp();
        test_zigzag();
        test_backpressure();
        test_back_to_back();
        test_sync_err();
        test_reset_mid();
        test_missing_last();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
